// File: rtl/xram_arbiter_pkg.sv
// Shared encodings and helpers for the two-master XRAM arbiter.
package xram_arbiter_pkg;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 8;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'b00,
        ARB_BUSY = 2'b01,
        ARB_GAP  = 2'b10
    } arb_state_e;

    localparam logic OWNER_PROC  = 1'b0;
    localparam logic OWNER_ACCEL = 1'b1;

    localparam logic [DATA_W-1:0] ARB_ERR_DATA = 8'hFF;

    // Winner when both masters request in the same IDLE cycle.
    function automatic logic tie_winner(input logic rr_en, input logic last_owner);
        return rr_en ? ~last_owner : OWNER_PROC;
    endfunction

endpackage

// File: rtl/xram_arbiter_wdog.sv
// Stall watchdog: counts BUSY cycles without completion and flags expiry.
module xram_arbiter_wdog #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic run,
    output logic expire
);

    localparam logic [15:0] LIMIT = 16'(TIMEOUT - 1);

    logic [15:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (run) begin
            cnt <= cnt + 16'd1;
        end
    end

    assign expire = run && (cnt == LIMIT);

endmodule

// File: rtl/xram_arbiter.sv
// Arbitrates the oc8051 core and the memwr copy engine onto the single XRAM port.
module xram_arbiter
    import xram_arbiter_pkg::*;
#(
    parameter bit          RR_EN   = 1'b1,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              proc_stb,
    input  logic              proc_wr,
    input  logic [ADDR_W-1:0] proc_addr,
    input  logic [DATA_W-1:0] proc_data_out,
    output logic [DATA_W-1:0] proc_data_in,
    output logic              proc_ack,
    input  logic              accel_stb,
    input  logic              accel_wr,
    input  logic [ADDR_W-1:0] accel_addr,
    input  logic [DATA_W-1:0] accel_data_out,
    output logic [DATA_W-1:0] accel_data_in,
    output logic              accel_ack,
    output logic              xram_stb,
    output logic              xram_wr,
    output logic [ADDR_W-1:0] xram_addr,
    output logic [DATA_W-1:0] xram_data_out,
    input  logic [DATA_W-1:0] xram_data_in,
    input  logic              xram_ack,
    output logic [1:0]        arb_state,
    output logic              arb_owner,
    output logic              arb_err
);

    arb_state_e        state;
    logic              owner;
    logic              busy;
    logic              any_stb;
    logic              owner_stb;
    logic              owner_wr;
    logic [ADDR_W-1:0] owner_addr;
    logic [DATA_W-1:0] owner_wdata;
    logic              xfer_ack;
    logic              expire;
    logic              ack_any;
    logic [DATA_W-1:0] rdata;

    assign busy    = (state == ARB_BUSY);
    assign any_stb = proc_stb || accel_stb;

    always_comb begin
        owner_stb   = proc_stb;
        owner_wr    = proc_wr;
        owner_addr  = proc_addr;
        owner_wdata = proc_data_out;
        if (owner == OWNER_ACCEL) begin
            owner_stb   = accel_stb;
            owner_wr    = accel_wr;
            owner_addr  = accel_addr;
            owner_wdata = accel_data_out;
        end
    end

    xram_arbiter_wdog #(
        .TIMEOUT(TIMEOUT)
    ) u_wdog (
        .clk   (clk),
        .rst   (rst),
        .clr   ((state == ARB_IDLE) && any_stb),
        .run   (busy && owner_stb && !xram_ack),
        .expire(expire)
    );

    // A dropped owner strobe is an abort: nothing is forwarded even if the XRAM acks.
    assign xfer_ack = busy && owner_stb && xram_ack;
    assign ack_any  = xfer_ack || expire;
    assign rdata    = xfer_ack ? xram_data_in : (expire ? ARB_ERR_DATA : '0);

    assign xram_stb      = busy && owner_stb && !expire;
    assign xram_wr       = busy && owner_wr;
    assign xram_addr     = busy ? owner_addr  : '0;
    assign xram_data_out = busy ? owner_wdata : '0;

    assign proc_ack      = ack_any && (owner == OWNER_PROC);
    assign proc_data_in  = (owner == OWNER_PROC)  ? rdata : '0;
    assign accel_ack     = ack_any && (owner == OWNER_ACCEL);
    assign accel_data_in = (owner == OWNER_ACCEL) ? rdata : '0;

    assign arb_state = state;
    assign arb_owner = owner;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ARB_IDLE;
            owner   <= OWNER_ACCEL;
            arb_err <= 1'b0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (any_stb) begin
                        state <= ARB_BUSY;
                        if (proc_stb && accel_stb) begin
                            owner <= tie_winner(RR_EN, owner);
                        end else begin
                            owner <= accel_stb ? OWNER_ACCEL : OWNER_PROC;
                        end
                    end
                end
                ARB_BUSY: begin
                    if (!owner_stb || xram_ack) begin
                        state <= ARB_GAP;
                    end else if (expire) begin
                        state   <= ARB_GAP;
                        arb_err <= 1'b1;
                    end
                end
                // Masters release stb only after the ack cycle, so skip one cycle before re-arbitrating.
                ARB_GAP: state <= ARB_IDLE;
                default: state <= ARB_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_xram_arbiter.sv
// Drives a round-robin and a fixed-priority arbiter with identical stimulus against a transaction model.
module tb_xram_arbiter;

    localparam int TMO = 8;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        proc_stb, proc_wr, accel_stb, accel_wr, xram_ack;
    logic [15:0] proc_addr, accel_addr;
    logic [7:0]  proc_data_out, accel_data_out, xram_data_in;

    logic [7:0]  proc_data_in_o [2];
    logic        proc_ack_o     [2];
    logic [7:0]  accel_data_in_o[2];
    logic        accel_ack_o    [2];
    logic        xram_stb_o     [2];
    logic        xram_wr_o      [2];
    logic [15:0] xram_addr_o    [2];
    logic [7:0]  xram_data_out_o[2];
    logic [1:0]  arb_state_o    [2];
    logic        arb_owner_o    [2];
    logic        arb_err_o      [2];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        xram_arbiter #(
            .RR_EN  (g == 0),
            .TIMEOUT(TMO)
        ) dut (
            .clk           (clk),
            .rst           (rst),
            .proc_stb      (proc_stb),
            .proc_wr       (proc_wr),
            .proc_addr     (proc_addr),
            .proc_data_out (proc_data_out),
            .proc_data_in  (proc_data_in_o[g]),
            .proc_ack      (proc_ack_o[g]),
            .accel_stb     (accel_stb),
            .accel_wr      (accel_wr),
            .accel_addr    (accel_addr),
            .accel_data_out(accel_data_out),
            .accel_data_in (accel_data_in_o[g]),
            .accel_ack     (accel_ack_o[g]),
            .xram_stb      (xram_stb_o[g]),
            .xram_wr       (xram_wr_o[g]),
            .xram_addr     (xram_addr_o[g]),
            .xram_data_out (xram_data_out_o[g]),
            .xram_data_in  (xram_data_in),
            .xram_ack      (xram_ack),
            .arb_state     (arb_state_o[g]),
            .arb_owner     (arb_owner_o[g]),
            .arb_err       (arb_err_o[g])
        );
    end

    int checks = 0;
    int errors = 0;

    // Transaction model: phase 0 idle, 1 granted, 2 turnaround; age = cycles spent granted so far.
    int   ph  [2];
    bit   own [2];
    int   age [2];
    bit   err [2];
    bit   fin [2];
    bit   tof [2];

    int          tick_n = 0;
    int          p_cnt[2];
    int          a_cnt[2];
    int          a_tick;
    logic [7:0]  last_pdata[2];
    logic [7:0]  last_adata[2];
    int          grant_q0[$];
    int          grant_q1[$];
    logic [15:0] addr_q[$];
    int          wr_low;
    bit          cap = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        tick_n++;
        for (int m = 0; m < 2; m++) begin
            logic        busy, ostb, done, to;
            logic [7:0]  rd;
            logic [31:0] ex, ep, ea, ec;
            busy = (ph[m] == 1);
            ostb = own[m] ? accel_stb : proc_stb;
            done = busy && ostb && xram_ack;
            to   = busy && ostb && !xram_ack && (age[m] == TMO);
            rd   = done ? xram_data_in : (to ? 8'hFF : 8'h00);
            ex   = '0;
            if (busy) begin
                ex = {6'b0, ostb && !to, own[m] ? accel_wr : proc_wr,
                      own[m] ? accel_addr : proc_addr, own[m] ? accel_data_out : proc_data_out};
            end
            ep = {23'b0, !own[m] && (done || to), own[m] ? 8'h00 : rd};
            ea = {23'b0,  own[m] && (done || to), own[m] ? rd : 8'h00};
            ec = {28'b0, 2'(ph[m]), own[m], err[m]};
            chk($sformatf("xram_side%0d", m),
                {6'b0, xram_stb_o[m], xram_wr_o[m], xram_addr_o[m], xram_data_out_o[m]}, ex);
            chk($sformatf("proc_side%0d", m),  {23'b0, proc_ack_o[m], proc_data_in_o[m]}, ep);
            chk($sformatf("accel_side%0d", m), {23'b0, accel_ack_o[m], accel_data_in_o[m]}, ea);
            chk($sformatf("status%0d", m),
                {28'b0, arb_state_o[m], arb_owner_o[m], arb_err_o[m]}, ec);
            fin[m] = busy && (!ostb || done || to);
            tof[m] = to;
            if (proc_ack_o[m] === 1'b1) begin
                p_cnt[m]++;
                last_pdata[m] = proc_data_in_o[m];
                if (m == 0) grant_q0.push_back(0); else grant_q1.push_back(0);
            end
            if (accel_ack_o[m] === 1'b1) begin
                a_cnt[m]++;
                last_adata[m] = accel_data_in_o[m];
                if (m == 0) begin
                    a_tick = tick_n;
                    grant_q0.push_back(1);
                end else begin
                    grant_q1.push_back(1);
                end
            end
        end
        if (cap && xram_stb_o[0] === 1'b1) begin
            addr_q.push_back(xram_addr_o[0]);
            if (xram_wr_o[0] !== 1'b1) wr_low++;
        end
        @(posedge clk);
        for (int m = 0; m < 2; m++) begin
            if (rst) begin
                ph[m] = 0; own[m] = 1'b1; age[m] = 0; err[m] = 1'b0;
            end else if (ph[m] == 0) begin
                if (proc_stb || accel_stb) begin
                    if (proc_stb && accel_stb) own[m] = (m == 0) ? !own[m] : 1'b0;
                    else                       own[m] = accel_stb;
                    ph[m]  = 1;
                    age[m] = 1;
                end
            end else if (ph[m] == 1) begin
                if (fin[m]) begin
                    ph[m] = 2;
                    if (tof[m]) err[m] = 1'b1;
                end else begin
                    age[m]++;
                end
            end else begin
                ph[m] = 0;
            end
        end
        #1;
    endtask

    task automatic idle_inputs();
        proc_stb = 0; proc_wr = 0; proc_addr = '0; proc_data_out = '0;
        accel_stb = 0; accel_wr = 0; accel_addr = '0; accel_data_out = '0;
        xram_ack = 0; xram_data_in = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        int          t0;
        int          pc0;
        logic [15:0] exp_addr[4];
        exp_addr = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
        for (int m = 0; m < 2; m++) begin
            p_cnt[m] = 0; a_cnt[m] = 0; last_pdata[m] = '0; last_adata[m] = '0;
        end
        a_tick = 0;
        wr_low = 0;
        idle_inputs();
        rst = 1'b1;
        @(posedge clk);
        for (int m = 0; m < 2; m++) begin
            ph[m] = 0; own[m] = 1'b1; age[m] = 0; err[m] = 1'b0;
        end
        #1;

        // Reset and idle
        tick();
        tick();
        rst = 1'b0;
        tick();
        tick();

        // Single proc read, XRAM answers in the second granted cycle
        proc_stb = 1; proc_addr = 16'h0123;
        tick();
        tick();
        xram_ack = 1; xram_data_in = 8'h5A;
        tick();
        proc_stb = 0; xram_ack = 0; xram_data_in = '0;
        tick();
        tick();
        chk("read_acks", 32'(p_cnt[0]), 32'd1);
        chk("read_data", 32'(last_pdata[0]), 32'h5A);

        // Tie with a zero-wait XRAM
        do_reset();
        grant_q0.delete();
        grant_q1.delete();
        proc_stb = 1; accel_stb = 1; xram_ack = 1; xram_data_in = 8'h11;
        repeat (12) tick();
        idle_inputs();
        tick();
        chk("rr_count", 32'(grant_q0.size()), 32'd4);
        chk("fp_count", 32'(grant_q1.size()), 32'd4);
        if (grant_q0.size() >= 4 && grant_q1.size() >= 4) begin
            for (int i = 0; i < 4; i++) begin
                chk($sformatf("rr_grant%0d", i), 32'(grant_q0[i]), 32'(i % 2));
                chk($sformatf("fp_grant%0d", i), 32'(grant_q1[i]), 32'd0);
            end
        end

        // memwr copy across the top of the address space
        do_reset();
        addr_q.delete();
        a_cnt[0] = 0;
        cap = 1'b1;
        for (int i = 0; i < 4; i++) begin
            accel_stb = 1; accel_wr = 1; accel_addr = exp_addr[i];
            accel_data_out = 8'(8'hA0 + i); xram_ack = 1;
            tick();
            tick();
            accel_stb = 0; xram_ack = 0;
            tick();
        end
        cap = 1'b0;
        chk("copy_acks", 32'(a_cnt[0]), 32'd4);
        chk("copy_beats", 32'(addr_q.size()), 32'd4);
        chk("copy_wr", 32'(wr_low), 32'd0);
        if (addr_q.size() >= 4) begin
            for (int i = 0; i < 4; i++) chk($sformatf("copy_addr%0d", i), 32'(addr_q[i]), 32'(exp_addr[i]));
        end

        // Watchdog expiry
        do_reset();
        accel_stb = 1; accel_addr = 16'h4000;
        t0 = tick_n;
        repeat (9) tick();
        accel_stb = 0;
        repeat (3) tick();
        chk("wdog_cycle", 32'(a_tick), 32'(t0 + 9));
        chk("wdog_data", 32'(last_adata[0]), 32'hFF);
        chk("wdog_err", 32'(arb_err_o[0]), 32'd1);

        // Ack coinciding with expiry
        do_reset();
        accel_stb = 1; accel_addr = 16'h4001;
        t0 = tick_n;
        repeat (8) tick();
        xram_ack = 1; xram_data_in = 8'h3C;
        tick();
        accel_stb = 0; xram_ack = 0; xram_data_in = '0;
        repeat (3) tick();
        chk("race_cycle", 32'(a_tick), 32'(t0 + 9));
        chk("race_data", 32'(last_adata[0]), 32'h3C);
        chk("race_err", 32'(arb_err_o[0]), 32'd0);

        // Abort by the owner, then reset while granted
        do_reset();
        pc0 = p_cnt[0];
        proc_stb = 1; proc_addr = 16'h0200;
        tick();
        tick();
        proc_stb = 0;
        tick();
        tick();
        proc_stb = 1;
        tick();
        tick();
        rst = 1;
        tick();
        rst = 0; proc_stb = 0; xram_ack = 1;
        tick();
        chk("rst_state", 32'(arb_state_o[0]), 32'd0);
        xram_ack = 0;
        tick();
        chk("abort_acks", 32'(p_cnt[0] - pc0), 32'd0);

        // Randomized traffic
        for (int blk = 0; blk < 12; blk++) begin
            int rate;
            rate = $urandom_range(0, 3);
            for (int i = 0; i < 50; i++) begin
                if ($urandom_range(0, 5) == 0) begin
                    proc_stb = !proc_stb; proc_wr = 1'($urandom);
                    proc_addr = 16'($urandom); proc_data_out = 8'($urandom);
                end
                if ($urandom_range(0, 5) == 0) begin
                    accel_stb = !accel_stb; accel_wr = 1'($urandom);
                    accel_addr = 16'($urandom); accel_data_out = 8'($urandom);
                end
                case (rate)
                    0:       xram_ack = 1'b0;
                    1:       xram_ack = 1'($urandom);
                    2:       xram_ack = ($urandom_range(0, 4) == 0);
                    default: xram_ack = 1'b1;
                endcase
                xram_data_in = 8'($urandom);
                rst = ($urandom_range(0, 199) == 0);
                tick();
            end
        end
        rst = 0;
        idle_inputs();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
